// File: rtl/mips_pkg.sv
// Shared types and constants for the mips instruction-fetch path.
package mips_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned WORD_W = 30;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  // One fetch pipeline stage; word is the full byte offset divided by four.
  typedef struct packed {
    logic              vld;
    logic              err;
    logic [WORD_W-1:0] word;
  } fetch_stage_t;

endpackage

// File: rtl/inst_rom_rsp_if.sv
// Fetch request/response bundle between the core IF stage and the instruction responder.
interface inst_rom_rsp_if;
  import mips_pkg::*;

  logic [31:0]       pc;
  logic              pc_vld;
  logic [INST_W-1:0] inst_data;
  logic              inst_vld;
  logic              addr_err;

  modport master (output pc, pc_vld, input inst_data, inst_vld, addr_err);
  modport slave  (input pc, pc_vld, output inst_data, inst_vld, addr_err);

endinterface

// File: rtl/inst_ram.sv
// Word-addressed single-clock RAM: one sync read port, one write port, old data on read-during-write.
module inst_ram
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [INST_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [INST_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [INST_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_rom_rsp.sv
// Instruction-memory responder: decodes fetch pc, delays it LATENCY-1 stages, then reads the RAM.
module inst_rom_rsp
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 1,
  parameter logic [31:0] RST_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_,
  inst_rom_rsp_if.slave     fetch,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [INST_W-1:0] ld_data,
  output logic [31:0]       fetch_cnt
);

  if (LATENCY == 0 || LATENCY > 4) begin : g_bad_latency
    $error("inst_rom_rsp: LATENCY must be in 1..4");
  end
  if (ADDR_W == 0 || ADDR_W > 29) begin : g_bad_addr_w
    $error("inst_rom_rsp: ADDR_W must be in 1..29");
  end

  logic [31:0]       w_off;
  fetch_stage_t      w_dec;
  fetch_stage_t      w_last;
  logic              w_rd_err;
  logic              w_rd_en;
  logic [INST_W-1:0] w_ram_rdata;
  logic              r_out_vld;
  logic              r_out_err;
  logic [31:0]       r_fetch_cnt;

  assign w_off = fetch.pc - RST_PC;
  assign w_dec = '{vld: fetch.pc_vld, err: |w_off[1:0], word: w_off[31:2]};

  // Request delay line; with LATENCY=1 the RAM is read straight from the decode.
  if (LATENCY == 1) begin : g_no_pipe
    assign w_last = w_dec;
  end else if (LATENCY <= 4) begin : g_pipe
    for (genvar s = 0; s < LATENCY - 1; s++) begin : g_stg
      fetch_stage_t r_stage;
      fetch_stage_t w_in;
      if (s == 0) begin : g_head
        assign w_in = w_dec;
      end else begin : g_tail
        assign w_in = g_stg[s-1].r_stage;
      end
      always_ff @(posedge clk) begin
        if (rst_) r_stage <= '0;
        else      r_stage <= w_in;
      end
    end
    assign w_last = g_stg[LATENCY-2].r_stage;
  end

  // The range check sits at the read stage so the whole word index travels down the pipe.
  assign w_rd_err = w_last.err | (|w_last.word[WORD_W-1:ADDR_W]);
  assign w_rd_en  = w_last.vld & ~w_rd_err;

  inst_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (ld_en & ~rst_),
    .i_waddr (ld_addr),
    .i_wdata (ld_data),
    .i_re    (w_rd_en),
    .i_raddr (w_last.word[ADDR_W-1:0]),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_out_vld   <= 1'b0;
      r_out_err   <= 1'b0;
      r_fetch_cnt <= 32'h0;
    end else begin
      r_out_vld <= w_last.vld;
      r_out_err <= w_last.vld & w_rd_err;
      if (fetch.pc_vld) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  // Bubbles and error fetches both present a NOP to the core.
  assign fetch.inst_data = (r_out_vld && !r_out_err) ? w_ram_rdata : NOP;
  assign fetch.inst_vld  = r_out_vld;
  assign fetch.addr_err  = r_out_err;
  assign fetch_cnt       = r_fetch_cnt;

endmodule

// File: tb/tb_inst_rom_rsp.sv
// Bench for inst_rom_rsp: LATENCY=1 and LATENCY=3 instances share stimulus, scoreboard checks every cycle.
module tb_inst_rom_rsp;
  import mips_pkg::*;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LAT3   = 3;

  logic              clk = 1'b0;
  logic              rst_;
  logic [31:0]       pc;
  logic              pc_vld;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic [31:0]       cnt1, cnt3;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [31:0] prog [4] = '{32'h3401_0011, 32'h3402_0022, 32'h3403_0033, 32'h3404_0044};

  inst_rom_rsp_if if1 ();
  inst_rom_rsp_if if3 ();

  assign if1.pc     = pc;
  assign if1.pc_vld = pc_vld;
  assign if3.pc     = pc;
  assign if3.pc_vld = pc_vld;

  always #5 clk = ~clk;

  inst_rom_rsp #(.ADDR_W(ADDR_W), .LATENCY(1), .RST_PC(32'h0)) u_l1 (
    .clk(clk), .rst_(rst_), .fetch(if1.slave),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(cnt1)
  );

  inst_rom_rsp #(.ADDR_W(ADDR_W), .LATENCY(LAT3), .RST_PC(32'h0)) u_l3 (
    .clk(clk), .rst_(rst_), .fetch(if3.slave),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(cnt3)
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int          due;
    logic [31:0] pc;
  } pend_t;

  pend_t       q1 [$];
  pend_t       q3 [$];
  logic [31:0] tb_mem [int];
  logic        exp_vld  [2];
  logic        exp_err  [2];
  logic [31:0] exp_data [2];
  logic [31:0] exp_cnt = 32'h0;
  int          edge_no = 0;

  function automatic logic model_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] a);
    int w;
    if (model_err(a)) return 32'h0;
    w = int'(a >> 2);
    return tb_mem.exists(w) ? tb_mem[w] : 32'hxxxx_xxxx;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      exp_vld[d] = 1'b0; exp_err[d] = 1'b0; exp_data[d] = 32'h0;
    end
  end

  // Requests are pushed at their accept edge and resolved against the memory model at their read edge.
  always @(posedge clk) begin : model
    pend_t p;
    for (int d = 0; d < 2; d++) begin
      exp_vld[d] = 1'b0; exp_err[d] = 1'b0; exp_data[d] = 32'h0;
    end
    if (rst_) begin
      q1.delete();
      q3.delete();
      exp_cnt = 32'h0;
    end else begin
      if (pc_vld) begin
        q1.push_back('{due: edge_no, pc: pc});
        q3.push_back('{due: edge_no + int'(LAT3) - 1, pc: pc});
        exp_cnt = exp_cnt + 32'd1;
      end
      if (q1.size() > 0 && q1[0].due == edge_no) begin
        p = q1.pop_front();
        exp_vld[0] = 1'b1; exp_err[0] = model_err(p.pc); exp_data[0] = model_data(p.pc);
      end
      if (q3.size() > 0 && q3[0].due == edge_no) begin
        p = q3.pop_front();
        exp_vld[1] = 1'b1; exp_err[1] = model_err(p.pc); exp_data[1] = model_data(p.pc);
      end
      if (ld_en) tb_mem[int'(ld_addr)] = ld_data;
    end
    edge_no++;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin : monitor
    logic        ov [2];
    logic        oe [2];
    logic [31:0] od [2];
    logic [31:0] oc [2];
    ov[0] = if1.inst_vld; oe[0] = if1.addr_err; od[0] = if1.inst_data; oc[0] = cnt1;
    ov[1] = if3.inst_vld; oe[1] = if3.addr_err; od[1] = if3.inst_data; oc[1] = cnt3;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if ({ov[d], oe[d], od[d]} !== {exp_vld[d], exp_err[d], exp_data[d]}) begin
          n_fail++;
          $display("FAIL sb_out_%s edge=%0d vld/err/data got %b/%b/%h need %b/%b/%h",
                   (d == 0) ? "l1" : "l3", edge_no, ov[d], oe[d], od[d],
                   exp_vld[d], exp_err[d], exp_data[d]);
        end
        n_cmp++;
        if (oc[d] !== exp_cnt) begin
          n_fail++;
          $display("FAIL sb_cnt_%s edge=%0d got %h need %h",
                   (d == 0) ? "l1" : "l3", edge_no, oc[d], exp_cnt);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] a, input logic le,
                       input logic [ADDR_W-1:0] la, input logic [31:0] ld);
    pc_vld = v; pc = a; ld_en = le; ld_addr = la; ld_data = ld;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, '0, 32'h0);
  endtask

  task automatic test_reset;
    rst_ = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({if1.inst_vld, if1.addr_err, if1.inst_data} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_out_l1 got %b/%b/%h need 0/0/0", if1.inst_vld, if1.addr_err, if1.inst_data);
    end
    n_cmp++;
    if ({if3.inst_vld, if3.addr_err, if3.inst_data} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_out_l3 got %b/%b/%h need 0/0/0", if3.inst_vld, if3.addr_err, if3.inst_data);
    end
    n_cmp++;
    if (cnt1 !== 32'h0 || cnt3 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cnt got %h/%h need 0/0", cnt1, cnt3);
    end
    rst_   = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic test_load_fetch;
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, ADDR_W'(i), prog[i]);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, '0, 32'h0);
      n_cmp++;
      if (if1.inst_vld !== 1'b1 || if1.inst_data !== prog[i]) begin
        n_fail++;
        $display("FAIL load_fetch_w%0d got vld=%b data=%h need vld=1 data=%h",
                 i, if1.inst_vld, if1.inst_data, prog[i]);
      end
    end
    idle(1);
    n_cmp++;
    if (cnt1 !== 32'd4) begin
      n_fail++;
      $display("FAIL load_fetch_cnt got %0d need 4", cnt1);
    end
    idle(3);
  endtask

  task automatic test_latency;
    logic [31:0] st_pc [8] = '{32'd0, 32'd4, 32'd0, 32'd0, 32'd8, 32'd12, 32'd0, 32'd0};
    logic        st_v  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        ev;
    logic [31:0] ed;
    for (int i = 0; i < 8; i++) begin
      drive(st_v[i], st_pc[i], 1'b0, '0, 32'h0);
      ev = (i >= 2) ? st_v[i-2] : 1'b0;
      ed = ev ? prog[st_pc[i-2] >> 2] : 32'h0;
      n_cmp++;
      if (if3.inst_vld !== ev || if3.inst_data !== ed) begin
        n_fail++;
        $display("FAIL latency3_c%0d got vld=%b data=%h need vld=%b data=%h",
                 i, if3.inst_vld, if3.inst_data, ev, ed);
      end
    end
    idle(2);
  endtask

  task automatic test_errors;
    logic [31:0] bad [2] = '{32'h0000_0002, 32'h0000_1000};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, bad[i], 1'b0, '0, 32'h0);
      n_cmp++;
      if ({if1.inst_vld, if1.addr_err, if1.inst_data} !== {1'b1, 1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL err_pc_%h got vld/err/data %b/%b/%h need 1/1/0",
                 bad[i], if1.inst_vld, if1.addr_err, if1.inst_data);
      end
    end
    idle(1);
    n_cmp++;
    if (cnt1 !== 32'd10 || cnt3 !== 32'd10) begin
      n_fail++;
      $display("FAIL err_cnt got %0d/%0d need 10/10", cnt1, cnt3);
    end
    idle(3);
  endtask

  task automatic test_rdw;
    drive(1'b0, 32'h0, 1'b1, ADDR_W'(5), 32'hAAAA_AAAA);
    drive(1'b1, 32'd20, 1'b1, ADDR_W'(5), 32'h5555_5555);
    n_cmp++;
    if (if1.inst_vld !== 1'b1 || if1.inst_data !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL rdw_old got vld=%b data=%h need vld=1 data=aaaaaaaa", if1.inst_vld, if1.inst_data);
    end
    drive(1'b1, 32'd20, 1'b0, '0, 32'h0);
    n_cmp++;
    if (if1.inst_vld !== 1'b1 || if1.inst_data !== 32'h5555_5555) begin
      n_fail++;
      $display("FAIL rdw_new got vld=%b data=%h need vld=1 data=55555555", if1.inst_vld, if1.inst_data);
    end
    idle(3);
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 32'd0, 1'b0, '0, 32'h0);
    drive(1'b1, 32'd4, 1'b0, '0, 32'h0);
    rst_ = 1'b1;
    drive(1'b1, 32'd8, 1'b1, ADDR_W'(0), 32'hDEAD_BEEF);
    rst_ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({if3.inst_vld, if3.addr_err, if3.inst_data, if1.inst_vld} !== 35'h0) begin
        n_fail++;
        $display("FAIL rst_mid_quiet_c%0d got l3 %b/%b/%h l1 vld=%b need all 0",
                 i, if3.inst_vld, if3.addr_err, if3.inst_data, if1.inst_vld);
      end
      idle(1);
    end
    drive(1'b1, 32'd0, 1'b0, '0, 32'h0);
    n_cmp++;
    if (if1.inst_vld !== 1'b1 || if1.inst_data !== prog[0]) begin
      n_fail++;
      $display("FAIL rst_mid_l1 got vld=%b data=%h need vld=1 data=%h", if1.inst_vld, if1.inst_data, prog[0]);
    end
    idle(1);
    n_cmp++;
    if (if3.inst_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_l3_early got vld=%b need 0", if3.inst_vld);
    end
    idle(1);
    n_cmp++;
    if (if3.inst_vld !== 1'b1 || if3.inst_data !== prog[0]) begin
      n_fail++;
      $display("FAIL rst_mid_l3 got vld=%b data=%h need vld=1 data=%h", if3.inst_vld, if3.inst_data, prog[0]);
    end
    n_cmp++;
    if (cnt3 !== 32'd1) begin
      n_fail++;
      $display("FAIL rst_mid_cnt got %0d need 1", cnt3);
    end
    idle(3);
  endtask

  task automatic test_wrap;
    logic [31:0] ec [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    #2;
    u_l1.r_fetch_cnt = 32'hFFFF_FFFE;
    u_l3.r_fetch_cnt = 32'hFFFF_FFFE;
    exp_cnt          = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, '0, 32'h0);
      n_cmp++;
      if (cnt1 !== ec[i] || cnt3 !== ec[i]) begin
        n_fail++;
        $display("FAIL wrap_c%0d got %h/%h need %h", i, cnt1, cnt3, ec[i]);
      end
    end
    idle(3);
  endtask

  initial begin
    rst_ = 1'b1; pc_vld = 1'b0; pc = 32'h0; ld_en = 1'b0; ld_addr = '0; ld_data = 32'h0;
    test_reset;
    test_load_fetch;
    test_latency;
    test_errors;
    test_rdw;
    test_reset_mid;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
